// File: rtl/clock_enable_gen.sv
// -----------------------------------------------------------------------------
// clock_enable_gen
//
// Multi-channel fractional clock-enable generator placed directly behind the
// system PLL. Each channel produces single-cycle enable strobes at an exact
// rational rate NUM/DEN of clk, using a modulo-DEN phase accumulator. All
// enables are held low until the PLL lock indicator has been stable for
// LOCK_DELAY consecutive synchronised cycles. A sync input restarts every
// accumulator at once so that the CPU, sound and video domains stay
// phase-coherent.
//
// Parameters:
//   CHANNELS   - number of enable outputs
//   WIDTH      - accumulator width; each NUM/DEN field is WIDTH bits
//   NUM        - packed numerators, channel i is NUM[i*WIDTH +: WIDTH]
//   DEN        - packed denominators, channel i is DEN[i*WIDTH +: WIDTH]
//   LOCK_DELAY - synchronised-lock cycles required before enables run
//
// Ports:
//   clk     in   system clock (PLL output)
//   rst_n   in   asynchronous active-low reset
//   locked  in   PLL lock indicator, asynchronous to clk
//   sync    in   synchronous phase realign, restarts all accumulators
//   ready   out  registered, high while enables are running
//   cen     out  registered single-cycle enables, bit i is channel i
// -----------------------------------------------------------------------------
module clock_enable_gen #(
  parameter int                        CHANNELS   = 2,
  parameter int                        WIDTH      = 16,
  parameter logic [CHANNELS*WIDTH-1:0] NUM        = {16'd1, 16'd1},
  parameter logic [CHANNELS*WIDTH-1:0] DEN        = {16'd15, 16'd10},
  parameter int                        LOCK_DELAY = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                locked,
  input  logic                sync,
  output logic                ready,
  output logic [CHANNELS-1:0] cen
);

  // The lock counter is a fixed 16-bit saturating counter, so the target
  // value is narrowed once here.
  localparam logic [15:0] LOCK_TARGET = 16'(LOCK_DELAY);

  // Reject a lock delay the 16-bit counter cannot represent, or a zero delay
  // that would let the enables start without any settling time.
  if (LOCK_DELAY < 1 || LOCK_DELAY > 65535) begin : gBadLockDelay
    $fatal(1, "clock_enable_gen: LOCK_DELAY must be in 1..65535");
  end

  logic        lockMeta_q;
  logic        lockS_q;
  logic [15:0] lockCnt_q;
  logic [15:0] lockCnt_d;
  logic        ready_q;
  logic        ready_d;
  logic        runEdge;

  // Two-flop synchroniser for the asynchronous PLL lock indicator. The first
  // flop may go metastable; only lockS_q is used by the rest of the design.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lockMeta_q <= 1'b0;
      lockS_q    <= 1'b0;
    end else begin
      lockMeta_q <= locked;
      lockS_q    <= lockMeta_q;
    end
  end

  // Lock settling counter. Any single low cycle of the synchronised lock
  // clears it, so the full settling time has to be seen again after a glitch.
  // It saturates at the target so a long-locked PLL keeps ready asserted.
  // ready_d is formed from the current counter value, which adds the one
  // register stage between the counter reaching the target and ready rising.
  always_comb begin
    lockCnt_d = lockCnt_q;
    if (!lockS_q) begin
      lockCnt_d = 16'd0;
    end else if (lockCnt_q != LOCK_TARGET) begin
      lockCnt_d = lockCnt_q + 16'd1;
    end
    ready_d = (lockCnt_q == LOCK_TARGET) && lockS_q;
  end

  // Lock counter and registered ready. ready doubles as the HOLD/RUN state:
  // low means HOLD, high means RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lockCnt_q <= 16'd0;
      ready_q   <= 1'b0;
    end else begin
      lockCnt_q <= lockCnt_d;
      ready_q   <= ready_d;
    end
  end

  assign ready = ready_q;

  // Accumulators advance only on edges where ready is already high and stays
  // high. Requiring the registered value keeps the edge where ready rises as
  // phase origin E0; requiring the next value makes cen drop on the very edge
  // where ready falls.
  assign runEdge = ready_q && ready_d;

  for (genvar i = 0; i < CHANNELS; i++) begin : gChan
    // Zero-extended operands so the sum of acc and NUM never wraps.
    localparam logic [WIDTH:0] NUM_X = {1'b0, NUM[i*WIDTH +: WIDTH]};
    localparam logic [WIDTH:0] DEN_X = {1'b0, DEN[i*WIDTH +: WIDTH]};

    // A channel with NUM of zero would never fire and one with NUM above DEN
    // would need more than one pulse per clock; both are configuration errors.
    if (NUM_X == '0 || NUM_X > DEN_X) begin : gBadRatio
      $fatal(1, "clock_enable_gen: channel %0d needs 0 < NUM <= DEN", i);
    end

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic             cen_q;
    logic             cen_d;
    logic [WIDTH:0]   sum;

    // Modulo-DEN phase accumulator. acc stays below DEN, so acc + NUM is
    // below 2*DEN and a single conditional subtraction brings it back into
    // range. Each subtraction is one enable strobe, giving exactly NUM pulses
    // every DEN cycles. HOLD takes priority over sync, and both restart the
    // channel from zero phase with cen low.
    always_comb begin
      sum   = {1'b0, acc_q} + NUM_X;
      acc_d = '0;
      cen_d = 1'b0;
      if (!runEdge || sync) begin
        acc_d = '0;
        cen_d = 1'b0;
      end else if (sum >= DEN_X) begin
        acc_d = WIDTH'(sum - DEN_X);
        cen_d = 1'b1;
      end else begin
        acc_d = WIDTH'(sum);
        cen_d = 1'b0;
      end
    end

    // Accumulator and enable registers for this channel.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_q <= '0;
        cen_q <= 1'b0;
      end else begin
        acc_q <= acc_d;
        cen_q <= cen_d;
      end
    end

    assign cen[i] = cen_q;
  end

endmodule

// File: tb/tb_clock_enable_gen.sv
// -----------------------------------------------------------------------------
// tb_clock_enable_gen
//
// Drives two clock_enable_gen instances from the same inputs:
//   dutA: 2 channels, WIDTH 16, 1/10 and 1/15, LOCK_DELAY 8
//   dutB: 3 channels, WIDTH 4, 5/5 (full rate), 3/8 and 1/7, LOCK_DELAY 5
// The reference model tracks ready as "locked has been sampled high for
// LOCK_DELAY+1 consecutive edges, seen through two synchroniser stages", and
// each enable as "floor(n*NUM/DEN) stepped up at cycle n of the current
// phase", where n counts edges since the last phase restart.
// -----------------------------------------------------------------------------
module tb_clock_enable_gen;

  localparam int LA = 8;
  localparam int LB = 5;
  localparam int HIST = 4096;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       locked;
  logic       sync;
  logic       readyA;
  logic [1:0] cenA;
  logic       readyB;
  logic [2:0] cenB;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int         t;
  int         runLen;
  int         runHist [HIST];
  int         originA;
  int         originB;
  logic       expReadyA;
  logic       expReadyB;
  logic [1:0] expCenA;
  logic [2:0] expCenB;
  int         numA [2] = '{1, 1};
  int         denA [2] = '{10, 15};
  int         numB [3] = '{5, 3, 1};
  int         denB [3] = '{5, 8, 7};

  always #5 clk = ~clk;

  clock_enable_gen #(
    .CHANNELS   (2),
    .WIDTH      (16),
    .NUM        ({16'd1, 16'd1}),
    .DEN        ({16'd15, 16'd10}),
    .LOCK_DELAY (LA)
  ) dutA (
    .clk    (clk),
    .rst_n  (rst_n),
    .locked (locked),
    .sync   (sync),
    .ready  (readyA),
    .cen    (cenA)
  );

  clock_enable_gen #(
    .CHANNELS   (3),
    .WIDTH      (4),
    .NUM        ({4'd1, 4'd3, 4'd5}),
    .DEN        ({4'd7, 4'd8, 4'd5}),
    .LOCK_DELAY (LB)
  ) dutB (
    .clk    (clk),
    .rst_n  (rst_n),
    .locked (locked),
    .sync   (sync),
    .ready  (readyB),
    .cen    (cenB)
  );

  // Ready after edge e needs locked sampled high on edges e-L-2 .. e-2.
  function automatic bit readyAt(int e, int l);
    if (e < 3) return 1'b0;
    return runHist[e-2] >= l + 1;
  endfunction

  // A pulse occurs at phase cycle n when the count of whole NUM/DEN steps
  // taken so far increases.
  function automatic bit pulseAt(int n, int num, int den);
    return ((n * num) / den) != (((n - 1) * num) / den);
  endfunction

  task automatic modelReset();
    t         = 0;
    runLen    = 0;
    runHist[0] = 0;
    originA   = 0;
    originB   = 0;
    expReadyA = 1'b0;
    expReadyB = 1'b0;
    expCenA   = '0;
    expCenB   = '0;
  endtask

  task automatic modelEdge(input bit lk, input bit sy);
    if (t < HIST - 1) t++;
    runLen     = lk ? runLen + 1 : 0;
    runHist[t] = runLen;
    expReadyA  = readyAt(t, LA);
    expReadyB  = readyAt(t, LB);
    if (!(readyAt(t - 1, LA) && expReadyA) || sy) begin
      originA = t;
      expCenA = '0;
    end else begin
      for (int i = 0; i < 2; i++) expCenA[i] = pulseAt(t - originA, numA[i], denA[i]);
    end
    if (!(readyAt(t - 1, LB) && expReadyB) || sy) begin
      originB = t;
      expCenB = '0;
    end else begin
      for (int i = 0; i < 3; i++) expCenB[i] = pulseAt(t - originB, numB[i], denB[i]);
    end
  endtask

  task automatic checkOutput();
    checks++;
    assert (readyA === expReadyA) else begin
      errors++;
      $error("[TB] FAIL readyA edge=%0d observed=%b expected=%b", t, readyA, expReadyA);
    end
    checks++;
    assert (cenA === expCenA) else begin
      errors++;
      $error("[TB] FAIL cenA edge=%0d observed=%b expected=%b", t, cenA, expCenA);
    end
    checks++;
    assert (readyB === expReadyB) else begin
      errors++;
      $error("[TB] FAIL readyB edge=%0d observed=%b expected=%b", t, readyB, expReadyB);
    end
    checks++;
    assert (cenB === expCenB) else begin
      errors++;
      $error("[TB] FAIL cenB edge=%0d observed=%b expected=%b", t, cenB, expCenB);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after
  // the rising edge that the model has just stepped.
  task automatic applyStimulus(input bit lk, input bit sy);
    @(negedge clk);
    locked = lk;
    sync   = sy;
    @(posedge clk);
    modelEdge(lk, sy);
    #1;
    checkOutput();
  endtask

  // Releases reset on a falling edge so the next rising edge is the first
  // modelled one.
  task automatic releaseReset(input bit lk);
    @(negedge clk);
    rst_n  = 1'b1;
    locked = lk;
    sync   = 1'b0;
    @(posedge clk);
    modelEdge(lk, 1'b0);
    #1;
    checkOutput();
  endtask

  initial begin
    int edges;
    int cntA0, cntA1, cntB0, cntB1;
    int firstA0, firstA1;
    int r;

    $display("[TB] clock_enable_gen bench start");
    rst_n  = 1'b0;
    locked = 1'b0;
    sync   = 1'b0;
    modelReset();

    // Outputs during reset, with locked high to show it is ignored.
    repeat (3) @(negedge clk);
    locked = 1'b1;
    @(negedge clk);
    checkOutput();
    @(negedge clk);
    checkOutput();

    // Lock acquisition: count edges from the first one sampling locked high.
    releaseReset(1'b1);
    edges = 1;
    while (readyA !== 1'b1 && edges < 100) begin
      applyStimulus(1'b1, 1'b0);
      edges++;
    end
    checks++;
    assert (edges === LA + 3) else begin
      errors++;
      $error("[TB] FAIL lockToReady observed=%0d expected=%0d", edges, LA + 3);
    end

    // 60 running cycles: 6 and 4 pulses on the integer channels, full rate
    // on dutB channel 0, and 3 pulses of 3/8 in the first 8-cycle window.
    cntA0 = 0; cntA1 = 0; cntB0 = 0; cntB1 = 0;
    for (int k = 0; k < 60; k++) begin
      applyStimulus(1'b1, 1'b0);
      if (cenA[0]) cntA0++;
      if (cenA[1]) cntA1++;
      if (cenB[0]) cntB0++;
      if (k < 8 && cenB[1]) cntB1++;
    end
    checks++;
    assert (cntA0 === 6) else begin
      errors++;
      $error("[TB] FAIL pulses1of10 observed=%0d expected=6", cntA0);
    end
    checks++;
    assert (cntA1 === 4) else begin
      errors++;
      $error("[TB] FAIL pulses1of15 observed=%0d expected=4", cntA1);
    end
    checks++;
    assert (cntB0 === 60) else begin
      errors++;
      $error("[TB] FAIL fullRate observed=%0d expected=60", cntB0);
    end
    checks++;
    assert (cntB1 === 3) else begin
      errors++;
      $error("[TB] FAIL pulses3of8 observed=%0d expected=3", cntB1);
    end

    // sync mid-pattern: next pulses exactly 10 and 15 edges later.
    repeat ($urandom_range(1, 9)) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    firstA0 = 0; firstA1 = 0;
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b1, 1'b0);
      if (cenA[0] && firstA0 == 0) firstA0 = k;
      if (cenA[1] && firstA1 == 0) firstA1 = k;
    end
    checks++;
    assert (firstA0 === 10) else begin
      errors++;
      $error("[TB] FAIL syncTo1of10 observed=%0d expected=10", firstA0);
    end
    checks++;
    assert (firstA1 === 15) else begin
      errors++;
      $error("[TB] FAIL syncTo1of15 observed=%0d expected=15", firstA1);
    end

    // One-cycle lock glitch: ready falls on the 3rd edge, then needs the
    // full settling time again.
    applyStimulus(1'b0, 1'b0);
    edges = 1;
    while (readyA !== 1'b0 && edges < 10) begin
      applyStimulus(1'b1, 1'b0);
      edges++;
    end
    checks++;
    assert (edges === 3) else begin
      errors++;
      $error("[TB] FAIL lockLossToHold observed=%0d expected=3", edges);
    end
    edges = edges - 1;
    while (readyA !== 1'b1 && edges < 100) begin
      applyStimulus(1'b1, 1'b0);
      edges++;
    end
    checks++;
    assert (edges === LA + 3) else begin
      errors++;
      $error("[TB] FAIL relockToReady observed=%0d expected=%0d", edges, LA + 3);
    end
    repeat (20) applyStimulus(1'b1, 1'b0);

    // Randomised section: occasional sync pulses and short lock drops.
    for (int k = 0; k < 400; k++) begin
      r = int'($urandom_range(0, 63));
      if (r < 3) begin
        repeat ($urandom_range(1, 3)) applyStimulus(1'b0, 1'($urandom_range(0, 1)));
      end else begin
        applyStimulus(1'b1, r < 7);
      end
    end

    // Asynchronous reset in the middle of a run.
    repeat (20) applyStimulus(1'b1, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput();
    repeat (2) @(posedge clk);
    releaseReset(1'b1);
    repeat (40) applyStimulus(1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_enable_gen.md
# clock_enable_gen

Multi-channel fractional clock-enable generator sitting directly behind the system PLL. It turns the single PLL output clock into CHANNELS single-cycle enable strobes, each at an exact rational rate NUM/DEN of the clock (for example 6 MHz and 4 MHz from 60 MHz). It holds every enable low until the PLL has reported lock for a programmable settling time. It also provides a phase-realign input, so the CPU, sound and video domains can be restarted coherently.

## Interface

Parameters:
- CHANNELS, 2: number of enable outputs.
- WIDTH, 16: accumulator width; NUM and DEN per channel are WIDTH bits.
- NUM, {16'd1, 16'd1}: packed CHANNELS×WIDTH numerators; channel i is NUM[i*WIDTH +: WIDTH].
- DEN, {16'd15, 16'd10}: packed CHANNELS×WIDTH denominators; channel i is DEN[i*WIDTH +: WIDTH].
- LOCK_DELAY, 1024: consecutive synchronised-lock cycles required before enables run; range 1..65535.

Ports:
- clk  in  1  system clock (PLL output).
- rst_n  in  1  asynchronous, active-low reset.
- locked  in  1  PLL lock indicator, asynchronous to clk.
- sync  in  1  synchronous phase realign; restarts all accumulators.
- ready  out  1  registered; high while enables are running.
- cen  out  CHANNELS  registered single-cycle enables; bit i belongs to channel i.

## Operation

- **Constraints (checked at elaboration):**
  - 0 < NUM[i] ≤ DEN[i] for every channel; violation is a fatal elaboration error.
  - NUM == DEN gives cen[i] high on every running cycle.
- **Lock synchroniser:** two-flop synchroniser on locked produces lock_s.
- **Lock counter:** 16-bit, saturating.
  - Clears on any cycle where lock_s is 0.
  - Otherwise increments until it equals LOCK_DELAY, then holds.
  - ready_next = (counter == LOCK_DELAY) && lock_s.
- **States (implicit in ready):**
  - HOLD (ready=0): accumulators forced to 0, cen forced to 0.
  - RUN (ready=1): accumulators advance.
  - HOLD→RUN when the counter reaches LOCK_DELAY.
  - RUN→HOLD on the first cycle lock_s is 0.
- **Accumulator per channel:**
  - Register acc[i], WIDTH bits; the sum is computed in WIDTH+1 bits: s = acc + NUM.
  - If s ≥ DEN: acc ← s − DEN and cen[i] ← 1.
  - Otherwise: acc ← s and cen[i] ← 0.
  - No overflow is possible because acc < DEN always holds.
- **Update condition:** an accumulator updates only on edges where registered ready is 1.
- **Priority per edge:** rst_n low > ready low (HOLD) > sync high > normal accumulate.
- **sync (in RUN):** all acc ← 0 and all cen ← 0 on that edge. Counting restarts on the next edge, so every channel is phase-aligned afterwards.
- **Average rate:** exactly NUM/DEN pulses per clock. Spacing between pulses is ⌊DEN/NUM⌋ or ⌈DEN/NUM⌉ cycles; with NUM=1 the spacing is exactly DEN.

## Timing

- **Reset values** (rst_n low, asynchronous): ready=0, cen=0, acc=0, lock counter=0, synchroniser flops=0.
- **locked rising to ready rising:**
  - 2 edges through the synchroniser, then LOCK_DELAY edges of counting, then 1 edge to register ready.
  - Total LOCK_DELAY+3 edges after the first edge that samples locked high.
- **locked falling to ready falling:** 3 edges (2 synchroniser + 1 register). cen is 0 from the same edge that ready falls.
- **First pulse:**
  - Let E0 be the edge at which ready becomes 1.
  - cen[i] first goes high after edge Ek, where k is the smallest integer with k·NUM ≥ DEN.
  - Example: NUM=1, DEN=10 gives first pulse after E10, then every 10 cycles.
- **Pulse width:** cen pulses are exactly one clock wide, except when NUM=DEN (continuously high).
- **sync latency:** sync sampled high at edge Es clears the pulse pattern. The next pulse follows the first-pulse rule, counting Es as E0.
- **Glitch on lock:** a lock_s low for even one cycle clears the counter, and the full LOCK_DELAY is required again.
- **rst_n deassertion:** asynchronous assert; the design expects deassertion synchronised externally. No output changes on the deassertion edge itself.

## Test plan

- **Reset and lock:**
  - Stimulus: LOCK_DELAY=8; hold rst_n low, then release with locked=1.
  - Required: ready=0 and cen=0 during reset; ready rises exactly 11 edges after the first edge sampling locked=1.
- **Integer divide:**
  - Stimulus: NUM=1/DEN=10 and NUM=1/DEN=15 at 60 MHz.
  - Required: first pulses at E10 and E15; thereafter periods of exactly 10 and 15 cycles; 6 and 4 pulses per 60 cycles.
- **Fractional divide:**
  - Stimulus: NUM=3, DEN=8.
  - Required: pulses at E3, E6, E8, E11, E14, E16; exactly 3 pulses in every 8-cycle window; acc never ≥ 8.
- **Lock loss mid-run:**
  - Stimulus: drop locked for 1 cycle while running.
  - Required: ready falls 3 edges later; cen held 0; ready re-rises LOCK_DELAY+3 edges after locked returns; the pulse pattern restarts from acc=0.
- **sync realign:**
  - Stimulus: pulse sync for 1 cycle mid-pattern with NUM=1/DEN=10 and NUM=1/DEN=15.
  - Required: both channels go low on that edge; next pulses occur exactly 10 and 15 edges after the sync edge.
- **Full rate and width:**
  - Stimulus: NUM=DEN=5 with WIDTH=4, CHANNELS=3.
  - Required: cen high on every RUN cycle; no X on any output; the other channels are unaffected.
